sobel_window_gen: RTL and testbench

- Streaming 3x3 window generator that feeds the Sobel convolution's 9-word window register file.
- Accepts one pixel per valid cycle in raster order, buffers the two previous image rows internally, and produces a complete 3x3 neighbourhood plus a one-cycle write-enable strobe.
- Its nine data outputs connect one-to-one to the register file's nine write-data inputs, and its strobe drives the register file's write enable.

---
 rtl/sobel_window_gen.sv | 120 ++++++++++++
 tb/tb_sobel_window_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two image rows and emits each complete
// neighbourhood, with a one-cycle write strobe, to the Sobel window register file.
module sobel_window_gen #(
  parameter int W     = 12,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          pix_valid,
  input  logic [W-1:0]  pix_in,
  output logic          WriteEn,
  output logic [W-1:0]  WriteData1,
  output logic [W-1:0]  WriteData2,
  output logic [W-1:0]  WriteData3,
  output logic [W-1:0]  WriteData4,
  output logic [W-1:0]  WriteData5,
  output logic [W-1:0]  WriteData6,
  output logic [W-1:0]  WriteData7,
  output logic [W-1:0]  WriteData8,
  output logic [W-1:0]  WriteData9,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          frame_done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [W-1:0]  lb1 [IMG_W];
  logic [W-1:0]  lb2 [IMG_W];
  logic [W-1:0]  win [9];
  logic [W-1:0]  top;
  logic [W-1:0]  mid;
  logic          accept;
  logic          col_last;
  logic          row_last;

  // clr wins over pix_valid: a pixel presented alongside clr is dropped.
  assign accept   = pix_valid & ~clr;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign top      = lb2[col];
  assign mid      = lb1[col];

  // Line buffers carry no reset; stale rows are masked by the row>=2 gate.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      WriteEn    <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else if (clr) begin
      col        <= '0;
      row        <= '0;
      WriteEn    <= 1'b0;
      frame_done <= 1'b0;
    end else if (accept) begin
      WriteEn    <= (row >= ROW_TWO) && (col >= COL_TWO);
      win_row    <= row - ROW_ONE;
      win_col    <= col - COL_ONE;
      frame_done <= row_last && col_last;
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_ONE;
      end else begin
        col <= col + COL_ONE;
      end
    end else begin
      WriteEn    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Window shifts left one column per accepted pixel; new column enters at the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= top;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= mid;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix_in;
    end
  end

  assign WriteData1 = win[0];
  assign WriteData2 = win[1];
  assign WriteData3 = win[2];
  assign WriteData4 = win[3];
  assign WriteData5 = win[4];
  assign WriteData6 = win[5];
  assign WriteData7 = win[6];
  assign WriteData8 = win[7];
  assign WriteData9 = win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: image-array reference model compared every cycle,
// plus literal checks of first/last windows for the directed frames.
module tb_sobel_window_gen;
  localparam int W     = 12;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int CW    = 3;
  localparam int RW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr = 1'b0;
  logic          pix_valid = 1'b0;
  logic [W-1:0]  pix_in = '0;
  logic          wr_en;
  logic [W-1:0]  d1, d2, d3, d4, d5, d6, d7, d8, d9;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic [W-1:0]  dut_d [9];

  int checks = 0;
  int errors = 0;

  sobel_window_gen #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .clr(clr), .pix_valid(pix_valid), .pix_in(pix_in),
    .WriteEn(wr_en),
    .WriteData1(d1), .WriteData2(d2), .WriteData3(d3),
    .WriteData4(d4), .WriteData5(d5), .WriteData6(d6),
    .WriteData7(d7), .WriteData8(d8), .WriteData9(d9),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  assign dut_d[0] = d1; assign dut_d[1] = d2; assign dut_d[2] = d3;
  assign dut_d[3] = d4; assign dut_d[4] = d5; assign dut_d[5] = d6;
  assign dut_d[6] = d7; assign dut_d[7] = d8; assign dut_d[8] = d9;

  // clock
  always #5 clk = ~clk;

  task automatic chk_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference model: stores the frame as an image and reads neighbourhoods from it
  logic [W-1:0] img [IMG_H][IMG_W];
  int           m_row = 0, m_col = 0;
  bit           exp_en = 0, exp_done = 0;
  logic [W-1:0] exp_win [9];
  int           exp_row = 0, exp_col = 0, exp_idx = 0;

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_row = 0; m_col = 0; exp_en = 0; exp_done = 0;
    end else if (pix_valid) begin
      img[m_row][m_col] = pix_in;
      exp_en = (m_row >= 2) && (m_col >= 2);
      if (exp_en) begin
        for (int k = 0; k < 9; k++) exp_win[k] = img[m_row-2+k/3][m_col-2+k%3];
        exp_row = m_row - 1;
        exp_col = m_col - 1;
        exp_idx = m_row * IMG_W + m_col + 1;
      end
      exp_done = (m_row == IMG_H-1) && (m_col == IMG_W-1);
      m_col++;
      if (m_col == IMG_W) begin
        m_col = 0;
        m_row++;
        if (m_row == IMG_H) m_row = 0;
      end
    end else begin
      exp_en = 0; exp_done = 0;
    end
  end

  // scoreboard log of every window the DUT emits
  logic [9*W-1:0] log_w[$];
  int             log_r[$], log_c[$], log_i[$];
  int             done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk_eq("rst_en", int'(wr_en), 0);
      chk_eq("rst_done", int'(frame_done), 0);
      chk_eq("rst_row", int'(win_row), 0);
      chk_eq("rst_col", int'(win_col), 0);
      for (int k = 0; k < 9; k++) chk_eq($sformatf("rst_d%0d", k+1), int'(dut_d[k]), 0);
    end else begin
      chk_eq("write_en", int'(wr_en), int'(exp_en));
      chk_eq("frame_done", int'(frame_done), int'(exp_done));
      if (frame_done) done_cnt++;
      if (wr_en && exp_en) begin
        logic [9*W-1:0] pk;
        for (int k = 0; k < 9; k++) begin
          chk_eq($sformatf("win_d%0d", k+1), int'(dut_d[k]), int'(exp_win[k]));
          pk[(8-k)*W +: W] = dut_d[k];
        end
        chk_eq("win_row", int'(win_row), exp_row);
        chk_eq("win_col", int'(win_col), exp_col);
        log_w.push_back(pk);
        log_r.push_back(int'(win_row));
        log_c.push_back(int'(win_col));
        log_i.push_back(exp_idx);
      end
    end
  end

  function automatic int word(input logic [9*W-1:0] e, input int k);
    return int'(e[(8-k)*W +: W]);
  endfunction

  // drivers
  task automatic drive(input bit v, input bit c, input logic [W-1:0] p);
    @(posedge clk); #1;
    pix_valid = v; clr = c; pix_in = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  // mode 0: continuous, 1: idle after every pixel, 2: random gaps; rnd picks random pixels
  task automatic run_frame(input int base, input int mode, input bit rnd);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        logic [W-1:0] p;
        p = rnd ? W'($urandom_range(0, 4095)) : W'(base + r*16 + c);
        drive(1'b1, 1'b0, p);
        if (mode == 1) idle(1);
        if (mode == 2) idle(int'($urandom_range(0, 2)));
      end
  endtask

  task automatic check_frame(input string nm, input int s, input int base);
    chk_eq({nm, "_first_d1"}, word(log_w[s], 0), base);
    chk_eq({nm, "_first_d5"}, word(log_w[s], 4), base + 'h11);
    chk_eq({nm, "_first_d9"}, word(log_w[s], 8), base + 'h22);
    chk_eq({nm, "_first_row"}, log_r[s], 1);
    chk_eq({nm, "_first_col"}, log_c[s], 1);
    chk_eq({nm, "_first_idx"}, log_i[s], 19);
    chk_eq({nm, "_last_d1"}, word(log_w[s+35], 0), base + 'h55);
    chk_eq({nm, "_last_d5"}, word(log_w[s+35], 4), base + 'h66);
    chk_eq({nm, "_last_d9"}, word(log_w[s+35], 8), base + 'h77);
    chk_eq({nm, "_last_row"}, log_r[s+35], 6);
    chk_eq({nm, "_last_col"}, log_c[s+35], 6);
  endtask

  initial begin
    int s, dc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_en", int'(wr_en), 0);
    chk_eq("reset_d5", int'(d5), 0);
    rst = 1'b0;

    // continuous frame
    s = log_w.size(); dc = done_cnt;
    run_frame(0, 0, 1'b0); idle(3);
    chk_eq("cont_windows", log_w.size() - s, 36);
    chk_eq("cont_done", done_cnt - dc, 1);
    if (log_w.size() - s >= 36) check_frame("cont", s, 0);

    // alternate idle cycles
    s = log_w.size(); dc = done_cnt;
    run_frame(0, 1, 1'b0); idle(3);
    chk_eq("alt_windows", log_w.size() - s, 36);
    chk_eq("alt_done", done_cnt - dc, 1);
    if (log_w.size() - s >= 36) check_frame("alt", s, 0);

    // back-to-back frames
    s = log_w.size(); dc = done_cnt;
    run_frame(0, 0, 1'b0);
    run_frame('h800, 0, 1'b0); idle(3);
    chk_eq("b2b_windows", log_w.size() - s, 72);
    chk_eq("b2b_done", done_cnt - dc, 2);
    if (log_w.size() - s >= 72) begin
      check_frame("b2b_f1", s, 0);
      check_frame("b2b_f2", s + 36, 'h800);
    end

    // reset mid-frame after 30 pixels
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, W'((i/8)*16 + i%8));
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk_eq("pre_rst_en", int'(wr_en), 1);
    chk_eq("pre_rst_d9", int'(d9), 'h035);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_rst_en", int'(wr_en), 0);
    chk_eq("async_rst_d9", int'(d9), 0);
    chk_eq("async_rst_row", int'(win_row), 0);
    @(posedge clk); #1 rst = 1'b0;
    s = log_w.size();
    run_frame(0, 0, 1'b0); idle(3);
    chk_eq("post_rst_windows", log_w.size() - s, 36);
    if (log_w.size() - s >= 36) check_frame("post_rst", s, 0);

    // clr together with a valid pixel at index 20
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, W'((i/8)*16 + i%8));
    drive(1'b1, 1'b1, 12'h024);
    drive(1'b0, 1'b0, '0);
    chk_eq("clr_no_en", int'(wr_en), 0);
    chk_eq("clr_no_done", int'(frame_done), 0);
    chk_eq("clr_keeps_d9", int'(d9), 'h023);
    s = log_w.size();
    run_frame(0, 0, 1'b0); idle(3);
    chk_eq("post_clr_windows", log_w.size() - s, 36);
    if (log_w.size() - s >= 36) check_frame("post_clr", s, 0);

    // random pixels with random gaps, model-checked
    for (int f = 0; f < 3; f++) begin
      s = log_w.size(); dc = done_cnt;
      run_frame(0, 2, 1'b1); idle(3);
      chk_eq("rand_windows", log_w.size() - s, 36);
      chk_eq("rand_done", done_cnt - dc, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
